// File: rtl/ushift_seq_pkg.sv
// Shared constants for the universal shift register sequencer:
// register mode selects and sequencer state encoding.
package ushift_seq_pkg;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHR  = 2'b01;
  localparam logic [1:0] SEL_SHL  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Commands that never touch the register: no-op, or a shift of zero cycles.
  function automatic logic is_null_cmd(input logic [1:0] op, input logic cnt_zero);
    logic r;
    r = 1'b0;
    case (op)
      SEL_HOLD: r = 1'b1;
      SEL_SHR,
      SEL_SHL:  r = cnt_zero;
      SEL_LOAD: r = 1'b0;
      default:  r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ushift_seq.sv
// Command sequencer for a universal shift register: turns one accepted
// load/shift command into the per-cycle sel/i_par/serial-input pattern.
module ushift_seq
  import ushift_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             clear_b,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] i_par,
  output logic             msb_in,
  output logic             lsb_in,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  state_t           r_state;
  logic [1:0]       r_op;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_data;

  state_t           w_state_nxt;
  logic [1:0]       w_op_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] w_data_nxt;
  logic [CNT_W-1:0] w_cnt_clamped;

  logic             w_ready;
  logic [1:0]       w_sel;
  logic [WIDTH-1:0] w_par;
  logic             w_msb;
  logic             w_lsb;
  logic             w_done;

  assign w_cnt_clamped = (cmd_cnt > CNT_MAX) ? CNT_MAX : cmd_cnt;

  // State register together with the inline down-counter and data shifter.
  always_ff @(posedge clk or negedge clear_b) begin
    if (!clear_b) begin
      r_state <= IDLE;
      r_op    <= SEL_HOLD;
      r_cnt   <= CNT_ZERO;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_cnt   <= w_cnt_nxt;
      r_data  <= w_data_nxt;
    end
  end

  // Next-state, command capture and per-cycle count/data update.
  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = r_data;
    case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          w_op_nxt   = cmd_op;
          w_data_nxt = cmd_data;
          w_cnt_nxt  = (cmd_op == SEL_LOAD) ? CNT_ONE : w_cnt_clamped;
          if (is_null_cmd(cmd_op, cmd_cnt == CNT_ZERO)) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = RUN;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        // Bit 0 feeds the register each cycle, so the next serial bit moves down.
        w_data_nxt = {1'b0, r_data[WIDTH-1:1]};
        w_cnt_nxt  = r_cnt - CNT_ONE;
        if (r_cnt == CNT_ONE) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = RUN;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Output decode from registered state only.
  always_comb begin
    w_ready = 1'b0;
    w_sel   = SEL_HOLD;
    w_par   = '0;
    w_msb   = 1'b0;
    w_lsb   = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
      end
      RUN: begin
        w_sel = r_op;
        case (r_op)
          SEL_SHR:  w_msb = r_data[0];
          SEL_SHL:  w_lsb = r_data[0];
          SEL_LOAD: w_par = r_data;
          default:  w_par = '0;
        endcase
      end
      DONE: begin
        w_done = 1'b1;
      end
      default: begin
        w_ready = 1'b0;
      end
    endcase
  end

  assign cmd_ready = w_ready;
  assign sel       = w_sel;
  assign i_par     = w_par;
  assign msb_in    = w_msb;
  assign lsb_in    = w_lsb;
  assign done      = w_done;

endmodule

// File: tb/tb_ushift_seq.sv
// Directed bench: ushift_seq driving a behavioural 4-bit universal shift register.
module tb_ushift_seq;
  import ushift_seq_pkg::*;

  logic       clk;
  logic       clear_b;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_cnt;
  logic [3:0] cmd_data;
  logic [1:0] sel;
  logic [3:0] i_par;
  logic       msb_in;
  logic       lsb_in;
  logic       done;
  logic [3:0] reg_q;

  int n_checks = 0;
  int n_errors = 0;

  ushift_seq #(.WIDTH(4), .CNT_W(3)) dut (
    .clk(clk), .clear_b(clear_b), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_data(cmd_data), .sel(sel),
    .i_par(i_par), .msb_in(msb_in), .lsb_in(lsb_in), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Universal shift register under control of the sequencer.
  always_ff @(posedge clk or negedge clear_b) begin
    if (!clear_b) reg_q <= 4'b0000;
    else begin
      case (sel)
        SEL_SHR:  reg_q <= {msb_in, reg_q[3:1]};
        SEL_SHL:  reg_q <= {reg_q[2:0], lsb_in};
        SEL_LOAD: reg_q <= i_par;
        default:  reg_q <= reg_q;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks the full output set in one go.
  task automatic chk_out(input string tag, input logic rdy, input logic [1:0] s,
                         input logic [3:0] p, input logic m, input logic l,
                         input logic d, input logic [3:0] r);
    chk({tag, ".ready"}, {7'd0, cmd_ready}, {7'd0, rdy});
    chk({tag, ".sel"},   {6'd0, sel},       {6'd0, s});
    chk({tag, ".i_par"}, {4'd0, i_par},     {4'd0, p});
    chk({tag, ".msb"},   {7'd0, msb_in},    {7'd0, m});
    chk({tag, ".lsb"},   {7'd0, lsb_in},    {7'd0, l});
    chk({tag, ".done"},  {7'd0, done},      {7'd0, d});
    chk({tag, ".reg"},   {4'd0, reg_q},     {4'd0, r});
  endtask

  // Presents a command at a negedge; returns at the negedge of cycle k+1.
  task automatic send(input logic [1:0] op, input logic [2:0] cnt, input logic [3:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_cnt   = cnt;
    cmd_data  = data;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_cnt   = 3'd0;
    cmd_data  = 4'b0000;
  endtask

  initial begin
    clear_b   = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_cnt   = 3'd0;
    cmd_data  = 4'b0000;

    // Reset asserted mid-cycle, checked before the first edge
    #2 clear_b = 1'b0;
    #1 chk_out("reset", 1'b1, SEL_HOLD, 4'h0, 1'b0, 1'b0, 1'b0, 4'b0000);
    @(negedge clk);
    clear_b = 1'b1;
    @(negedge clk);
    chk_out("idle", 1'b1, SEL_HOLD, 4'h0, 1'b0, 1'b0, 1'b0, 4'b0000);

    // Load 1101
    send(SEL_LOAD, 3'd0, 4'b1101);
    chk_out("load.k1", 1'b0, SEL_LOAD, 4'b1101, 1'b0, 1'b0, 1'b0, 4'b0000);
    @(negedge clk);
    chk_out("load.k2", 1'b0, SEL_HOLD, 4'h0, 1'b0, 1'b0, 1'b1, 4'b1101);
    @(negedge clk);
    chk_out("load.k3", 1'b1, SEL_HOLD, 4'h0, 1'b0, 1'b0, 1'b0, 4'b1101);

    // Shift right 2, serial bits 1,0
    send(SEL_SHR, 3'd2, 4'b0001);
    chk_out("shr.k1", 1'b0, SEL_SHR, 4'h0, 1'b1, 1'b0, 1'b0, 4'b1101);
    @(negedge clk);
    chk_out("shr.k2", 1'b0, SEL_SHR, 4'h0, 1'b0, 1'b0, 1'b0, 4'b1110);
    @(negedge clk);
    chk_out("shr.k3", 1'b0, SEL_HOLD, 4'h0, 1'b0, 1'b0, 1'b1, 4'b0111);
    @(negedge clk);
    chk_out("shr.k4", 1'b1, SEL_HOLD, 4'h0, 1'b0, 1'b0, 1'b0, 4'b0111);

    // Shift left 3, serial bits 1,0,1
    send(SEL_SHL, 3'd3, 4'b0101);
    chk_out("shl.k1", 1'b0, SEL_SHL, 4'h0, 1'b0, 1'b1, 1'b0, 4'b0111);
    @(negedge clk);
    chk_out("shl.k2", 1'b0, SEL_SHL, 4'h0, 1'b0, 1'b0, 1'b0, 4'b1111);
    @(negedge clk);
    chk_out("shl.k3", 1'b0, SEL_SHL, 4'h0, 1'b0, 1'b1, 1'b0, 4'b1110);
    @(negedge clk);
    chk_out("shl.k4", 1'b0, SEL_HOLD, 4'h0, 1'b0, 1'b0, 1'b1, 4'b1101);
    @(negedge clk);
    chk_out("shl.k5", 1'b1, SEL_HOLD, 4'h0, 1'b0, 1'b0, 1'b0, 4'b1101);

    // Count 7 clamps to 4 cycles: msb sequence 0,1,0,1
    send(SEL_SHR, 3'd7, 4'b1010);
    chk_out("clamp.k1", 1'b0, SEL_SHR, 4'h0, 1'b0, 1'b0, 1'b0, 4'b1101);
    @(negedge clk);
    chk_out("clamp.k2", 1'b0, SEL_SHR, 4'h0, 1'b1, 1'b0, 1'b0, 4'b0110);
    @(negedge clk);
    chk_out("clamp.k3", 1'b0, SEL_SHR, 4'h0, 1'b0, 1'b0, 1'b0, 4'b1011);
    @(negedge clk);
    chk_out("clamp.k4", 1'b0, SEL_SHR, 4'h0, 1'b1, 1'b0, 1'b0, 4'b0101);
    @(negedge clk);
    chk_out("clamp.k5", 1'b0, SEL_HOLD, 4'h0, 1'b0, 1'b0, 1'b1, 4'b1010);
    @(negedge clk);
    chk_out("clamp.k6", 1'b1, SEL_HOLD, 4'h0, 1'b0, 1'b0, 1'b0, 4'b1010);

    // Zero-count shift goes straight to done
    send(SEL_SHL, 3'd0, 4'b1111);
    chk_out("zero.k1", 1'b0, SEL_HOLD, 4'h0, 1'b0, 1'b0, 1'b1, 4'b1010);
    @(negedge clk);
    chk_out("zero.k2", 1'b1, SEL_HOLD, 4'h0, 1'b0, 1'b0, 1'b0, 4'b1010);

    // No-op also completes at k+1
    send(SEL_HOLD, 3'd3, 4'b1111);
    chk_out("nop.k1", 1'b0, SEL_HOLD, 4'h0, 1'b0, 1'b0, 1'b1, 4'b1010);
    @(negedge clk);
    chk_out("nop.k2", 1'b1, SEL_HOLD, 4'h0, 1'b0, 1'b0, 1'b0, 4'b1010);

    // Valid held through RUN/DONE: second command waits for cmd_ready
    cmd_valid = 1'b1; cmd_op = SEL_SHR; cmd_cnt = 3'd1; cmd_data = 4'b0001;
    @(negedge clk);
    cmd_op = SEL_LOAD; cmd_cnt = 3'd0; cmd_data = 4'b0110;
    chk_out("hold.k1", 1'b0, SEL_SHR, 4'h0, 1'b1, 1'b0, 1'b0, 4'b1010);
    @(negedge clk);
    chk_out("hold.k2", 1'b0, SEL_HOLD, 4'h0, 1'b0, 1'b0, 1'b1, 4'b1101);
    @(negedge clk);
    chk_out("hold.k3", 1'b1, SEL_HOLD, 4'h0, 1'b0, 1'b0, 1'b0, 4'b1101);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 4'b0000;
    chk_out("hold.k4", 1'b0, SEL_LOAD, 4'b0110, 1'b0, 1'b0, 1'b0, 4'b1101);
    @(negedge clk);
    chk_out("hold.k5", 1'b0, SEL_HOLD, 4'h0, 1'b0, 1'b0, 1'b1, 4'b0110);
    @(negedge clk);
    chk_out("hold.k6", 1'b1, SEL_HOLD, 4'h0, 1'b0, 1'b0, 1'b0, 4'b0110);

    // Abort during the 2nd cycle of a 4-shift
    send(SEL_SHR, 3'd4, 4'b1111);
    chk_out("abort.k1", 1'b0, SEL_SHR, 4'h0, 1'b1, 1'b0, 1'b0, 4'b0110);
    @(negedge clk);
    chk_out("abort.k2", 1'b0, SEL_SHR, 4'h0, 1'b1, 1'b0, 1'b0, 4'b1011);
    clear_b = 1'b0;
    #1 chk_out("abort.rst", 1'b1, SEL_HOLD, 4'h0, 1'b0, 1'b0, 1'b0, 4'b0000);
    @(negedge clk);
    chk_out("abort.held", 1'b1, SEL_HOLD, 4'h0, 1'b0, 1'b0, 1'b0, 4'b0000);
    clear_b = 1'b1;
    @(negedge clk);
    chk_out("abort.after1", 1'b1, SEL_HOLD, 4'h0, 1'b0, 1'b0, 1'b0, 4'b0000);
    @(negedge clk);
    chk_out("abort.after2", 1'b1, SEL_HOLD, 4'h0, 1'b0, 1'b0, 1'b0, 4'b0000);

    // Sequencer works normally after the abort
    send(SEL_LOAD, 3'd5, 4'b1001);
    chk_out("post.k1", 1'b0, SEL_LOAD, 4'b1001, 1'b0, 1'b0, 1'b0, 4'b0000);
    @(negedge clk);
    chk_out("post.k2", 1'b0, SEL_HOLD, 4'h0, 1'b0, 1'b0, 1'b1, 4'b1001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
